// File: rtl/display_pkg.sv
// Shared constants and types for the score digit sequencer.
package display_pkg;

    localparam logic [7:0] CHAR_ZERO  = 8'h30;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic {
        IDLE,
        CONVERT
    } conv_state_t;

    // 10**n, evaluated at elaboration time for range limits and checks.
    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bcd_ascii_encode.sv
// Maps a packed BCD vector to per-digit ASCII codes, blanking leading zeros.
module bcd_ascii_encode
    import display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic [4*NUM_DIGITS-1:0]      bcd,
    output logic [NUM_DIGITS-1:0][7:0]   chars
);

    // Digit 0 is the most significant nibble; the last digit is never blanked.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic [3:0] digit;
        assign digit = bcd[4*(NUM_DIGITS-1-i) +: 4];

        if (BLANK_LEADING && (i < NUM_DIGITS - 1)) begin : g_blank
            // Blank when this digit and every digit to its left are zero.
            assign chars[i] = (bcd[4*NUM_DIGITS-1 -: 4*(i+1)] == '0)
                            ? CHAR_SPACE : CHAR_ZERO + 8'(digit);
        end else begin : g_show
            assign chars[i] = CHAR_ZERO + 8'(digit);
        end
    end

endmodule

// File: rtl/score_digit_sequencer.sv
// Serial double-dabble converter with a shadow buffer committed at frame start.
module score_digit_sequencer
    import display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned BIN_WIDTH     = 14,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BIN_WIDTH-1:0]        value,
    input  logic                        load,
    input  logic                        frame_start,
    output logic                        busy,
    output logic                        done,
    output logic [NUM_DIGITS-1:0][7:0]  chars
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);
    localparam logic [BIN_WIDTH-1:0] MAX_VALUE = BIN_WIDTH'(pow10(NUM_DIGITS) - 64'd1);
    localparam logic [CNT_W-1:0]     LAST_ITER = CNT_W'(BIN_WIDTH - 1);

    // Elaboration-time parameter sanity checks.
    if (NUM_DIGITS < 1 || NUM_DIGITS > 6) begin : g_bad_digits
        $error("score_digit_sequencer: NUM_DIGITS must be in 1..6");
    end
    if ((64'd1 << BIN_WIDTH) < pow10(NUM_DIGITS)) begin : g_bad_width
        $error("score_digit_sequencer: BIN_WIDTH too narrow for NUM_DIGITS");
    end

    conv_state_t                 state_q, state_d;
    logic                        start_c, last_c;
    logic [CNT_W-1:0]            cnt_q;
    logic [BIN_WIDTH-1:0]        bin_q, bin_step, sat_value;
    logic [BCD_W-1:0]            bcd_q, bcd_adj, bcd_step;
    logic [NUM_DIGITS-1:0][7:0]  shadow_q, enc_chars, zero_chars;
    logic                        pending_q;
    logic                        unused_bcd_msb;

    assign sat_value = (value > MAX_VALUE) ? MAX_VALUE : value;

    // Add-3 correction on every nibble that would overflow when doubled.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_adj
        assign bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                             : bcd_q[4*i +: 4];
    end

    // Shift {bcd, bin} left by one; saturation keeps the shifted-out BCD bit zero.
    assign bcd_step       = {bcd_adj[BCD_W-2:0], bin_q[BIN_WIDTH-1]};
    assign bin_step       = {bin_q[BIN_WIDTH-2:0], 1'b0};
    assign unused_bcd_msb = bcd_adj[BCD_W-1];

    bcd_ascii_encode #(
        .NUM_DIGITS    (NUM_DIGITS),
        .BLANK_LEADING (BLANK_LEADING)
    ) u_enc_result (
        .bcd   (bcd_step),
        .chars (enc_chars)
    );

    bcd_ascii_encode #(
        .NUM_DIGITS    (NUM_DIGITS),
        .BLANK_LEADING (BLANK_LEADING)
    ) u_enc_zero (
        .bcd   ({BCD_W{1'b0}}),
        .chars (zero_chars)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start_c accepts a load, last_c marks the final iteration.
    always_comb begin
        state_d = state_q;
        start_c = 1'b0;
        last_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    start_c = 1'b1;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                if (cnt_q == LAST_ITER) begin
                    last_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Conversion datapath, shadow buffer and frame-aligned commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            bin_q     <= '0;
            bcd_q     <= '0;
            shadow_q  <= zero_chars;
            chars     <= zero_chars;
            pending_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= last_c;

            if (start_c) begin
                busy  <= 1'b1;
                bin_q <= sat_value;
                bcd_q <= '0;
                cnt_q <= '0;
            end else if (state_q == CONVERT) begin
                bin_q <= bin_step;
                bcd_q <= bcd_step;
                cnt_q <= cnt_q + CNT_W'(1);
                if (last_c) begin
                    busy <= 1'b0;
                end
            end

            if (last_c) begin
                shadow_q <= enc_chars;
            end

            // Commit uses the pending flag from before this edge.
            if (frame_start && pending_q) begin
                chars <= shadow_q;
            end
            pending_q <= last_c | (pending_q & ~frame_start);
        end
    end

endmodule

// File: tb/tb_score_digit_sequencer.sv
// Randomized self-checking bench for score_digit_sequencer against a decimal model.
module tb_score_digit_sequencer;

    localparam int unsigned ND = 4;
    localparam int unsigned BW = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic              load;
    logic              frame_start;
    logic [BW-1:0]     value;
    logic              busy, done, busy_nb, done_nb;
    logic [ND-1:0][7:0] chars, chars_nb;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int disp      = 0;

    always #5 clk = ~clk;

    score_digit_sequencer #(.NUM_DIGITS(ND), .BIN_WIDTH(BW), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .frame_start(frame_start),
        .busy(busy), .done(done), .chars(chars)
    );

    score_digit_sequencer #(.NUM_DIGITS(ND), .BIN_WIDTH(BW), .BLANK_LEADING(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .value(value), .load(load), .frame_start(frame_start),
        .busy(busy_nb), .done(done_nb), .chars(chars_nb)
    );

    // Decimal rendering of a value: saturate, split into digits, blank leading zeros.
    function automatic logic [ND-1:0][7:0] exp_chars(input int v, input bit blank);
        logic [ND-1:0][7:0] r;
        int s, d, div;
        bit lead;
        s    = (v > 9999) ? 9999 : v;
        div  = 1000;
        lead = 1'b1;
        for (int i = 0; i < ND; i++) begin
            d    = (s / div) % 10;
            div  = div / 10;
            lead = lead && (d == 0);
            r[i] = (blank && i < ND - 1 && lead) ? 8'h20 : 8'(8'h30 + d);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one load and step until done; frame_start is raised for the cycle after tick fs_at.
    task automatic run_conv(input int v, input int fs_at, input int reload_at, input int reload_v,
                            output int lat, output bit busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        value   = BW'(v);
        load    = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            load = (k == reload_at);
            if (k == reload_at) value = BW'(reload_v);
            frame_start = (k == fs_at);
            if (done === 1'b1) begin
                lat = k;
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        load = 1'b0;
        if (lat < 0) frame_start = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; frame_start = 1'b0; value = '0;
        repeat (3) tick();
        total_cnt++;
        if (chars !== exp_chars(0, 1'b1) || chars_nb !== exp_chars(0, 1'b0))
            $display("FAIL reset_chars got=%h/%h exp=%h/%h", chars, chars_nb,
                     exp_chars(0, 1'b1), exp_chars(0, 1'b0));
        else pass_cnt++;
        rst  = 1'b0;
        disp = 0;
        for (int n = 0; n < 5; n++) begin
            repeat (3) tick();
            pulse_frame();
            total_cnt++;
            if (chars !== exp_chars(disp, 1'b1) || chars_nb !== exp_chars(disp, 1'b0) ||
                busy !== 1'b0 || done !== 1'b0 || busy_nb !== 1'b0 || done_nb !== 1'b0)
                $display("FAIL reset_idle[%0d] chars=%h/%h busy=%b/%b done=%b/%b exp chars=%h busy=0 done=0",
                         n, chars, chars_nb, busy, busy_nb, done, done_nb, exp_chars(disp, 1'b1));
            else pass_cnt++;
        end
    endtask

    task automatic test_basic();
        int lat; bit bok;
        run_conv(1234, 15, 0, 0, lat, bok);
        total_cnt++;
        if (lat != 15 || !bok || done_nb !== 1'b1)
            $display("FAIL basic_latency got lat=%0d busy_ok=%b done_nb=%b exp lat=15 busy_ok=1 done_nb=1",
                     lat, bok, done_nb);
        else pass_cnt++;
        total_cnt++;
        if (chars !== exp_chars(disp, 1'b1))
            $display("FAIL basic_hold_in_done got=%h exp=%h", chars, exp_chars(disp, 1'b1));
        else pass_cnt++;
        tick();
        frame_start = 1'b0;
        disp = 1234;
        total_cnt++;
        if (chars !== exp_chars(disp, 1'b1) || chars_nb !== exp_chars(disp, 1'b0) || done !== 1'b0)
            $display("FAIL basic_commit got=%h/%h done=%b exp=%h/%h done=0", chars, chars_nb, done,
                     exp_chars(disp, 1'b1), exp_chars(disp, 1'b0));
        else pass_cnt++;
    endtask

    task automatic test_late_commit();
        int lat; bit bok;
        run_conv(7, 0, 0, 0, lat, bok);
        repeat (40) tick();
        total_cnt++;
        if (lat != 15 || !bok || chars !== exp_chars(disp, 1'b1))
            $display("FAIL late_wait got lat=%0d busy_ok=%b chars=%h exp lat=15 busy_ok=1 chars=%h",
                     lat, bok, chars, exp_chars(disp, 1'b1));
        else pass_cnt++;
        pulse_frame();
        disp = 7;
        total_cnt++;
        if (chars !== exp_chars(disp, 1'b1) || chars_nb !== exp_chars(disp, 1'b0))
            $display("FAIL late_commit got=%h/%h exp=%h/%h", chars, chars_nb,
                     exp_chars(disp, 1'b1), exp_chars(disp, 1'b0));
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        int vals[4] = '{16383, 10000, 9999, 0};
        int lat; bit bok;
        foreach (vals[j]) begin
            run_conv(vals[j], 15, 0, 0, lat, bok);
            tick();
            frame_start = 1'b0;
            disp = vals[j];
            total_cnt++;
            if (lat != 15 || !bok || chars !== exp_chars(disp, 1'b1) || chars_nb !== exp_chars(disp, 1'b0))
                $display("FAIL saturation[%0d] lat=%0d busy_ok=%b got=%h/%h exp=%h/%h", vals[j], lat, bok,
                         chars, chars_nb, exp_chars(disp, 1'b1), exp_chars(disp, 1'b0));
            else pass_cnt++;
        end
    endtask

    task automatic test_ignored_load();
        int lat; bit bok;
        run_conv(42, 10, 5, 99, lat, bok);
        total_cnt++;
        if (lat != 15 || !bok || chars !== exp_chars(disp, 1'b1))
            $display("FAIL ignored_load_done lat=%0d busy_ok=%b chars=%h exp lat=15 busy_ok=1 chars=%h",
                     lat, bok, chars, exp_chars(disp, 1'b1));
        else pass_cnt++;
        repeat (5) tick();
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0 || chars !== exp_chars(disp, 1'b1))
            $display("FAIL ignored_load_idle busy=%b done=%b chars=%h exp busy=0 done=0 chars=%h",
                     busy, done, chars, exp_chars(disp, 1'b1));
        else pass_cnt++;
        pulse_frame();
        disp = 42;
        total_cnt++;
        if (chars !== exp_chars(disp, 1'b1) || chars_nb !== exp_chars(disp, 1'b0))
            $display("FAIL ignored_load_commit got=%h/%h exp=%h/%h", chars, chars_nb,
                     exp_chars(disp, 1'b1), exp_chars(disp, 1'b0));
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat; bit bok;
        // Pending result committed on the same edge that completes the next one.
        run_conv(321, 0, 0, 0, lat, bok);
        run_conv(8765, 14, 0, 0, lat, bok);
        disp = 321;
        total_cnt++;
        if (lat != 15 || !bok || chars !== exp_chars(disp, 1'b1))
            $display("FAIL b2b_same_edge lat=%0d busy_ok=%b chars=%h exp lat=15 busy_ok=1 chars=%h",
                     lat, bok, chars, exp_chars(disp, 1'b1));
        else pass_cnt++;
        repeat (3) tick();
        pulse_frame();
        disp = 8765;
        total_cnt++;
        if (chars !== exp_chars(disp, 1'b1))
            $display("FAIL b2b_second_commit got=%h exp=%h", chars, exp_chars(disp, 1'b1));
        else pass_cnt++;
        // Two uncommitted results: only the latest is shown.
        run_conv(55, 0, 0, 0, lat, bok);
        run_conv(600, 0, 0, 0, lat, bok);
        tick();
        pulse_frame();
        disp = 600;
        total_cnt++;
        if (chars !== exp_chars(disp, 1'b1) || chars_nb !== exp_chars(disp, 1'b0))
            $display("FAIL b2b_overwrite got=%h/%h exp=%h/%h", chars, chars_nb,
                     exp_chars(disp, 1'b1), exp_chars(disp, 1'b0));
        else pass_cnt++;
    endtask

    task automatic test_random();
        int lat, v, fs_at; bit bok;
        for (int n = 0; n < 10; n++) begin
            v     = int'($urandom_range(0, 16383));
            fs_at = int'($urandom_range(1, 15));
            run_conv(v, fs_at, 0, 0, lat, bok);
            total_cnt++;
            if (lat != 15 || !bok || chars !== exp_chars(disp, 1'b1))
                $display("FAIL random_done[%0d] v=%0d lat=%0d busy_ok=%b chars=%h exp lat=15 busy_ok=1 chars=%h",
                         n, v, lat, bok, chars, exp_chars(disp, 1'b1));
            else pass_cnt++;
            if (fs_at == 15) begin
                tick();
                frame_start = 1'b0;
            end else begin
                repeat ($urandom_range(0, 5)) tick();
                pulse_frame();
            end
            disp = v;
            total_cnt++;
            if (chars !== exp_chars(disp, 1'b1) || chars_nb !== exp_chars(disp, 1'b0))
                $display("FAIL random_commit[%0d] v=%0d got=%h/%h exp=%h/%h", n, v, chars, chars_nb,
                         exp_chars(disp, 1'b1), exp_chars(disp, 1'b0));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        int lat; bit bok; bit saw_done;
        value = BW'(5555);
        load  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            load = 1'b0;
        end
        total_cnt++;
        if (busy !== 1'b1)
            $display("FAIL reset_mid_busy got=%b exp=1", busy);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        disp = 0;
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0 || chars !== exp_chars(disp, 1'b1) || chars_nb !== exp_chars(disp, 1'b0))
            $display("FAIL reset_mid_async busy=%b done=%b chars=%h/%h exp busy=0 done=0 chars=%h/%h",
                     busy, done, chars, chars_nb, exp_chars(disp, 1'b1), exp_chars(disp, 1'b0));
        else pass_cnt++;
        repeat (2) tick();
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (20) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        total_cnt++;
        if (saw_done)
            $display("FAIL reset_mid_no_done got activity=1 exp activity=0");
        else pass_cnt++;
        run_conv(10, 15, 0, 0, lat, bok);
        tick();
        frame_start = 1'b0;
        disp = 10;
        total_cnt++;
        if (lat != 15 || !bok || chars !== exp_chars(disp, 1'b1) || chars_nb !== exp_chars(disp, 1'b0))
            $display("FAIL reset_mid_reload lat=%0d busy_ok=%b got=%h/%h exp=%h/%h", lat, bok, chars, chars_nb,
                     exp_chars(disp, 1'b1), exp_chars(disp, 1'b0));
        else pass_cnt++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_late_commit();
        test_saturation();
        test_ignored_load();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
